// File: rtl/fft_stream_framer.sv
// AXI-Stream framer feeding an FFT core, plus per-bin power and per-frame peak on its output.
// Define FFT_FRAMER_PEAK_EN to build the peak tracker; otherwise the peak outputs are tied to 0.

module fft_stream_framer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 10,
  parameter int unsigned DIV    = 50
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     continuous,
  input  logic signed [DATA_W-1:0] sample,
  output logic [2*DATA_W-1:0]      s_tdata,
  output logic                     s_tvalid,
  output logic                     s_tlast,
  input  logic                     s_tready,
  input  logic [2*DATA_W-1:0]      m_tdata,
  input  logic [15:0]              m_tuser,
  input  logic                     m_tvalid,
  input  logic                     m_tlast,
  output logic                     m_tready,
  output logic [2*DATA_W-1:0]      mag,
  output logic [LOG2_N-1:0]        mag_idx,
  output logic                     mag_valid,
  output logic [2*DATA_W-1:0]      peak_mag,
  output logic [LOG2_N-1:0]        peak_idx,
  output logic                     peak_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  StbMax   = CNT_W'(DIV - 1);
  localparam logic [LOG2_N-1:0] LastBeat = LOG2_N'((1 << LOG2_N) - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // ---------------------------------------------------------------------------
  // Sample strobe
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stb_cnt_q;
  logic             stb;

  assign stb = (stb_cnt_q == StbMax);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      stb_cnt_q <= '0;
    end else if (stb) begin
      stb_cnt_q <= '0;
    end else begin
      stb_cnt_q <= stb_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Input framing FSM
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [LOG2_N-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                tvalid_q, tvalid_d;
  logic                overrun_q, overrun_d;
  logic                handshake;
  logic                last_beat;
  logic                keep_run;

  assign handshake = tvalid_q & s_tready;
  assign last_beat = (beat_cnt_q == LastBeat);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    sample_d   = sample_q;
    tvalid_d   = tvalid_q;
    overrun_d  = overrun_q;
    keep_run   = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          beat_cnt_d = '0;
          overrun_d  = 1'b0;
        end
      end
      StRun: begin
        if (handshake) begin
          tvalid_d   = 1'b0;
          beat_cnt_d = beat_cnt_q + LOG2_N'(1);
          if (last_beat && !continuous) begin
            state_d  = StIdle;
            keep_run = 1'b0;
          end
        end
        // A strobe while the beat is stalled is lost; one on the handshake cycle is taken.
        if (stb) begin
          if (tvalid_q && !s_tready) begin
            overrun_d = 1'b1;
          end else if (keep_run) begin
            sample_d = sample;
            tvalid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      sample_q   <= '0;
      tvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      sample_q   <= sample_d;
      tvalid_q   <= tvalid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign s_tdata  = {{DATA_W{1'b0}}, sample_q};
  assign s_tvalid = tvalid_q;
  assign s_tlast  = tvalid_q & last_beat;
  assign busy     = (state_q != StIdle);
  assign overrun  = overrun_q;

  // ---------------------------------------------------------------------------
  // Power pipeline
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0]   m_re, m_im;
  logic signed [2*DATA_W-1:0] re_sq, im_sq;
  logic [2*DATA_W-1:0]        sq_re_q, sq_im_q;
  logic [LOG2_N-1:0]          p1_idx_q;
  logic                       p1_valid_q, p1_last_q;
  logic [2*DATA_W-1:0]        mag_q;
  logic [LOG2_N-1:0]          mag_idx_q;
  logic                       mag_valid_q, mag_last_q;
  logic                       unused_tuser;

  assign m_re         = m_tdata[DATA_W-1:0];
  assign m_im         = m_tdata[2*DATA_W-1:DATA_W];
  assign re_sq        = m_re * m_re;
  assign im_sq        = m_im * m_im;
  assign m_tready     = 1'b1;
  assign unused_tuser = ^m_tuser[15:LOG2_N];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      p1_idx_q    <= '0;
      p1_valid_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      mag_q       <= '0;
      mag_idx_q   <= '0;
      mag_valid_q <= 1'b0;
      mag_last_q  <= 1'b0;
    end else begin
      p1_valid_q  <= m_tvalid;
      mag_valid_q <= p1_valid_q;
      if (m_tvalid) begin
        sq_re_q   <= re_sq;
        sq_im_q   <= im_sq;
        p1_idx_q  <= m_tuser[LOG2_N-1:0];
        p1_last_q <= m_tlast;
      end
      // Squares are non-negative and their sum peaks at 2^(2*DATA_W-1), so no carry out.
      if (p1_valid_q) begin
        mag_q      <= sq_re_q + sq_im_q;
        mag_idx_q  <= p1_idx_q;
        mag_last_q <= p1_last_q;
      end
    end
  end

  assign mag       = mag_q;
  assign mag_idx   = mag_idx_q;
  assign mag_valid = mag_valid_q;

  // ---------------------------------------------------------------------------
  // Peak tracker
  // ---------------------------------------------------------------------------
`ifdef FFT_FRAMER_PEAK_EN
  logic [2*DATA_W-1:0] run_mag_q, new_mag, peak_mag_q;
  logic [LOG2_N-1:0]   run_idx_q, new_idx, peak_idx_q;
  logic                first_q, peak_valid_q;

  // Strictly greater keeps the lower bin on ties.
  always_comb begin
    new_mag = run_mag_q;
    new_idx = run_idx_q;
    if (first_q || (mag_q > run_mag_q)) begin
      new_mag = mag_q;
      new_idx = mag_idx_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      run_mag_q    <= '0;
      run_idx_q    <= '0;
      first_q      <= 1'b1;
      peak_mag_q   <= '0;
      peak_idx_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (mag_valid_q) begin
        run_mag_q <= new_mag;
        run_idx_q <= new_idx;
        first_q   <= mag_last_q;
        if (mag_last_q) begin
          peak_mag_q   <= new_mag;
          peak_idx_q   <= new_idx;
          peak_valid_q <= 1'b1;
        end
      end
    end
  end

  assign peak_mag   = peak_mag_q;
  assign peak_idx   = peak_idx_q;
  assign peak_valid = peak_valid_q;
`else
  logic unused_mag_last;

  assign unused_mag_last = mag_last_q;
  assign peak_mag        = '0;
  assign peak_idx        = '0;
  assign peak_valid      = 1'b0;
`endif

endmodule
